// File: rtl/hazard_scheduler.sv
// Issue/stall controller for the 5-stage in-order core: pending-write scoreboard,
// RAW/WAW detection, multi-cycle multiply sequencing and branch flush controls.
module hazard_scheduler #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid_inst,
    input  logic [4:0]       id_rs1_idx,
    input  logic [4:0]       id_rs2_idx,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_reg_wr,
    input  logic [4:0]       id_dest_idx,
    input  logic             id_is_mul,
    input  logic             wb_valid_inst,
    input  logic             wb_reg_wr,
    input  logic [4:0]       wb_dest_idx,
    input  logic             ex_take_branch,
    output logic             stall_if,
    output logic             bubble_id,
    output logic             flush_if_id,
    output logic             ex_hold,
    output logic             id_issue,
    output logic [31:0]      sb_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] MUL_INIT  = 4'(MUL_LAT - 1);
    localparam logic       MUL_MULTI = (MUL_LAT > 1);

    state_t      state;
    logic [3:0]  mul_cnt;
    logic [1:0]  pend [32];

    logic        mul_busy;
    logic        raw;
    logic        waw;
    logic        haz;
    logic [31:0] inc_vec;
    logic [31:0] dec_vec;

    // Hazards look only at registered pend, so a same-cycle WB cannot release a stall.
    always_comb begin
        mul_busy = (state == BUSY);
        raw = (id_uses_rs1 && (id_rs1_idx != 5'd0) && (pend[id_rs1_idx] != 2'd0)) ||
              (id_uses_rs2 && (id_rs2_idx != 5'd0) && (pend[id_rs2_idx] != 2'd0));
        waw = id_reg_wr && (id_dest_idx != 5'd0) && (pend[id_dest_idx] == 2'd3);
        haz = id_valid_inst && (raw || waw || mul_busy);
    end

    assign stall_if    = haz & ~ex_take_branch;
    assign bubble_id   = haz | ex_take_branch;
    assign flush_if_id = ex_take_branch;
    assign id_issue    = id_valid_inst & ~haz & ~ex_take_branch;

    always_comb begin
        sb_busy = '0;
        for (int i = 1; i < 32; i++) begin
            sb_busy[i] = (pend[i] != 2'd0);
        end
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (id_issue && id_reg_wr && (id_dest_idx != 5'd0)) begin
            inc_vec[id_dest_idx] = 1'b1;
        end
        if (wb_valid_inst && wb_reg_wr && (wb_dest_idx != 5'd0) && (pend[wb_dest_idx] != 2'd0)) begin
            dec_vec[wb_dest_idx] = 1'b1;
        end
    end

    // Increment cannot overflow: a writer to a register already at 3 is held by waw.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                pend[i] <= 2'd0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    pend[i] <= pend[i] + 2'd1;
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    pend[i] <= pend[i] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mul_cnt <= 4'd0;
            ex_hold <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (id_issue && id_is_mul && MUL_MULTI) begin
                        state   <= BUSY;
                        mul_cnt <= MUL_INIT;
                        ex_hold <= 1'b1;
                    end
                end
                BUSY: begin
                    if (mul_cnt <= 4'd1) begin
                        state   <= IDLE;
                        mul_cnt <= 4'd0;
                        ex_hold <= 1'b0;
                    end else begin
                        mul_cnt <= mul_cnt - 4'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mul_cnt <= 4'd0;
                    ex_hold <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall_if) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule
